// File: rtl/fifo_pkg.sv
// Shared parameters, types and helpers for the FIFO read-side packer.
package fifo_pkg;

  localparam int FIFO_WIDTH   = 4;
  localparam int PACK_DEFAULT = 2;

  function automatic int count_width(input int pack);
    return $clog2(pack + 1);
  endfunction

  typedef logic [FIFO_WIDTH*PACK_DEFAULT-1:0] packed_word_t;

  localparam logic ZERO_FILL_BIT = 1'b0;

endpackage

// File: rtl/nibble_assembler.sv
// Assembly register for the packer: slot array, fill count, capture and clear.
module nibble_assembler
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int PACK  = PACK_DEFAULT,
  localparam int CW   = count_width(PACK)
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  capture,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  clear,
  output logic [CW-1:0]         cnt,
  output logic [CW-1:0]         fill,
  output logic [WIDTH*PACK-1:0] word
);

  logic [WIDTH-1:0] slots [PACK];

  assign fill = cnt + CW'(capture);

  // View of the word including this edge's capture; slots past the fill point
  // are zero because every clear zeroes the whole array.
  always_comb begin
    word = '0;
    for (int i = 0; i < PACK; i++) begin
      if (capture && (CW'(i) == cnt)) begin
        word[i*WIDTH +: WIDTH] = rdata;
      end else begin
        word[i*WIDTH +: WIDTH] = slots[i];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < PACK; i++) begin
        slots[i] <= {WIDTH{ZERO_FILL_BIT}};
      end
    end else if (clear) begin
      cnt <= '0;
      for (int i = 0; i < PACK; i++) begin
        slots[i] <= {WIDTH{ZERO_FILL_BIT}};
      end
    end else if (capture) begin
      cnt <= cnt + CW'(1);
      for (int i = 0; i < PACK; i++) begin
        if (CW'(i) == cnt) begin
          slots[i] <= rdata;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_nibble_packer.sv
// Drains the async FIFO read port, packs PACK entries per word and presents
// each word on a valid/ready stream. Runs entirely in the FIFO read domain.
module fifo_nibble_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int PACK  = PACK_DEFAULT,
  localparam int CW   = count_width(PACK)
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  empty,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  rd_rq,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH*PACK-1:0] m_data,
  output logic [CW-1:0]         m_count
);

  logic                  pend;
  logic                  flush_pend;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         fill;
  logic [WIDTH*PACK-1:0] word;
  logic                  out_free;
  logic                  word_full;
  logic                  flush_ready;
  logic                  xfer;

  // Counting the in-flight read keeps the assembly register from overfilling.
  assign rd_rq = rst_n && !empty && !flush_pend &&
                 ((int'(cnt) + int'(pend)) < PACK);

  assign out_free    = !m_valid || m_ready;
  assign word_full   = (int'(fill) == PACK);
  assign flush_ready = flush_pend && !pend && (cnt != '0);
  assign xfer        = (word_full || flush_ready) && out_free;

  nibble_assembler #(
    .WIDTH (WIDTH),
    .PACK  (PACK)
  ) u_asm (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .capture (pend),
    .rdata   (rdata),
    .clear   (xfer),
    .cnt     (cnt),
    .fill    (fill),
    .word    (word)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      flush_pend <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_count    <= '0;
    end else begin
      pend <= rd_rq;

      // An idle flush has nothing to emit and retires on its own.
      if (flush) begin
        flush_pend <= 1'b1;
      end else if (flush_pend && (xfer || ((cnt == '0) && !pend))) begin
        flush_pend <= 1'b0;
      end

      if (xfer) begin
        m_valid <= 1'b1;
        m_data  <= word;
        m_count <= fill;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Directed bench for fifo_nibble_packer: a FIFO model feeds the DUT and a
// scoreboard monitor checks every word presented on the output stream.
`timescale 1ns/1ps
module tb_fifo_nibble_packer;
  import fifo_pkg::*;

  localparam int WIDTH = 4;
  localparam int PACK  = 2;
  localparam int CW    = count_width(PACK);

  logic                  clk_in  = 1'b0;
  logic                  rst_n   = 1'b1;
  logic                  flush   = 1'b0;
  logic                  m_ready = 1'b1;
  logic [WIDTH-1:0]      rdata   = '0;
  logic                  empty;
  logic                  rd_rq;
  logic                  m_valid;
  logic [WIDTH*PACK-1:0] m_data;
  logic [CW-1:0]         m_count;

  typedef struct {
    packed_word_t  data;
    logic [CW-1:0] count;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] mem [64];
  int               wr_ptr   = 0;
  int               rd_ptr   = 0;
  int               checks   = 0;
  int               failures = 0;

  fifo_nibble_packer #(
    .WIDTH (WIDTH),
    .PACK  (PACK)
  ) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .empty   (empty),
    .rdata   (rdata),
    .rd_rq   (rd_rq),
    .flush   (flush),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_count (m_count)
  );

  always #5 clk_in = ~clk_in;

  // FIFO model: data appears on rdata one edge after an accepted read.
  assign empty = (wr_ptr == rd_ptr);
  always @(posedge clk_in) begin
    if (rd_rq) begin
      rdata  <= mem[rd_ptr[5:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr++;
  endtask

  task automatic expect_word(input packed_word_t d, input logic [CW-1:0] c);
    exp_t e;
    e.data  = d;
    e.count = c;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk_in);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%0h required=none", m_data);
        end else begin
          check("sb_m_data", m_data, exp_q[0].data);
          check("sb_m_count", m_count, exp_q[0].count);
          if (m_ready) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check("reset_rd_rq", rd_rq, 0);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_m_count", m_count, 0);
    check("reset_cnt", dut.u_asm.cnt, 0);
    check("reset_pend", dut.pend, 0);
    check("reset_flush_pend", dut.flush_pend, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic pack: reads at k, k+1; word at k+2 for exactly one cycle
    push(4'h3);
    push(4'hA);
    expect_word(8'hA3, 2);
    @(negedge clk_in);
    check("basic_rd_rq_k", rd_rq, 1);
    @(negedge clk_in);
    check("basic_rd_rq_k1", rd_rq, 1);
    check("basic_no_valid_k1", m_valid, 0);
    @(negedge clk_in);
    check("basic_rd_rq_done", rd_rq, 0);
    check("basic_no_valid_k2", m_valid, 0);
    @(negedge clk_in);
    check("basic_valid_k2", m_valid, 1);
    @(negedge clk_in);
    check("basic_valid_one_cycle", m_valid, 0);
    tick();

    // Back-pressure: first word held, second word assembled and parked
    m_ready = 1'b0;
    push(4'h1);
    push(4'h2);
    push(4'h3);
    push(4'h4);
    expect_word(8'h21, 2);
    expect_word(8'h43, 2);
    repeat (10) tick();
    @(negedge clk_in);
    check("bp_cnt_full", dut.u_asm.cnt, 2);
    check("bp_rd_rq_blocked", rd_rq, 0);
    check("bp_valid_held", m_valid, 1);
    check("bp_data_held", m_data, 8'h21);
    tick();
    m_ready = 1'b1;
    @(negedge clk_in);
    check("bp_first_word", m_data, 8'h21);
    @(negedge clk_in);
    check("bp_second_valid", m_valid, 1);
    check("bp_second_word", m_data, 8'h43);
    @(negedge clk_in);
    check("bp_drained", m_valid, 0);
    tick();

    // Flush partial: one entry, then flush; reads blocked until the transfer
    push(4'h7);
    expect_word(8'h07, 1);
    tick();
    tick();
    check("fp_cnt_one", dut.u_asm.cnt, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push(4'h8);
    expect_word(8'h08, 1);
    @(negedge clk_in);
    check("fp_rd_blocked", rd_rq, 0);
    check("fp_flush_pend", dut.flush_pend, 1);
    @(negedge clk_in);
    check("fp_valid", m_valid, 1);
    check("fp_count", m_count, 1);
    check("fp_rd_resume", rd_rq, 1);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();

    // Flush on the same edge as a read: the in-flight entry is still emitted
    push(4'hB);
    expect_word(8'h0B, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fi_pend", dut.pend, 1);
    check("fi_flush_pend", dut.flush_pend, 1);
    check("fi_rd_rq", rd_rq, 0);
    tick();
    check("fi_captured", dut.u_asm.cnt, 1);
    tick();
    check("fi_valid", m_valid, 1);
    check("fi_count", m_count, 1);
    check("fi_data", m_data, 8'h0B);
    check("fi_flush_done", dut.flush_pend, 0);
    tick();
    tick();

    // Flush while idle: no output, flush_pend clears one cycle later
    check("fid_idle_cnt", dut.u_asm.cnt, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fid_set", dut.flush_pend, 1);
    tick();
    check("fid_clear", dut.flush_pend, 0);
    check("fid_no_valid", m_valid, 0);
    tick();
    check("fid_no_valid_later", m_valid, 0);

    // Reset mid-word: partial entry discarded, outputs clear asynchronously
    push(4'h9);
    tick();
    tick();
    check("rst_cnt_before", dut.u_asm.cnt, 1);
    rst_n = 1'b0;
    push(4'h5);
    push(4'h6);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_count", m_count, 0);
    check("rst_m_data", m_data, 0);
    check("rst_rd_rq", rd_rq, 0);
    check("rst_cnt", dut.u_asm.cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    expect_word(8'h65, 2);
    repeat (6) tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
